// File: rtl/iter_controller.sv
// Multi-pass sequencing controller: waits for ready, strobes load once per pass,
// and aborts through a one-cycle flush on error, overflow or ready-timeout.
module iter_controller #(
    parameter int ITER_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ITER_W-1:0] num_iter,
    input  logic              ready,
    input  logic              error,
    input  logic              ov_flag,
    output logic              flush,
    output logic              load,
    output logic              controller_inuse,
    output logic              done,
    output logic [1:0]        status,
    output logic [ITER_W-1:0] iter_cnt
);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;
    localparam bit TMO_EN = (TIMEOUT != 0);

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_ERROR    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT  = 2'b10;
    localparam logic [1:0] ST_OVERFLOW = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [ITER_W-1:0] num_iter_reg, num_iter_next;
    logic [ITER_W-1:0] iter_cnt_reg, iter_cnt_next;
    logic [1:0]        status_reg, status_next;
    logic [TMO_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
    logic [ITER_W-1:0] iter_inc;

    assign iter_inc = iter_cnt_reg + ITER_W'(1);

    always_comb begin
        state_next    = state_reg;
        num_iter_next = num_iter_reg;
        iter_cnt_next = iter_cnt_reg;
        status_next   = status_reg;
        // Counter only advances while waiting in LOAD, so every entry starts at zero.
        tmo_cnt_next  = '0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    num_iter_next = num_iter;
                    iter_cnt_next = '0;
                    status_next   = ST_OK;
                    state_next    = (num_iter != '0) ? S_LOAD : S_DONE;
                end
            end
            S_LOAD: begin
                if (error) begin
                    status_next = ST_ERROR;
                    state_next  = S_FLUSH;
                end else if (ready) begin
                    state_next = S_CALC;
                end else if (TMO_EN && (tmo_cnt_reg == TMO_LAST)) begin
                    status_next = ST_TIMEOUT;
                    state_next  = S_FLUSH;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
                end
            end
            S_CALC: begin
                if (ov_flag) begin
                    status_next = ST_OVERFLOW;
                    state_next  = S_FLUSH;
                end else begin
                    iter_cnt_next = iter_inc;
                    state_next    = (iter_inc == num_iter_reg) ? S_DONE : S_LOAD;
                end
            end
            S_FLUSH: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            num_iter_reg <= '0;
            iter_cnt_reg <= '0;
            status_reg   <= ST_OK;
            tmo_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            num_iter_reg <= num_iter_next;
            iter_cnt_reg <= iter_cnt_next;
            status_reg   <= status_next;
            tmo_cnt_reg  <= tmo_cnt_next;
        end
    end

    assign load             = (state_reg == S_CALC);
    assign flush            = (state_reg == S_FLUSH);
    assign done             = (state_reg == S_DONE);
    assign controller_inuse = (state_reg == S_LOAD) || (state_reg == S_CALC) ||
                              (state_reg == S_FLUSH);
    assign status           = status_reg;
    assign iter_cnt         = iter_cnt_reg;

endmodule
